// File: rtl/exp3_sweep_ctrl_if.sv
// Bundle between the exp_3 self-test sequencer, its front end and the exp_3 block.
// Latency: none (wires only).
// Backpressure: none; start/abort are single-cycle pulses, status outputs are levels.
// Ports/signals:
//   start, abort          : front-end requests to the sequencer
//   dut_a/b/c             : vector driven to the exp_3 block
//   dut_x/y               : exp_3 outputs returned to the sequencer
//   busy, done, pass      : sweep status
//   err_count, fail_mask  : mismatch summary of the last sweep
//   results               : captured {y,x} per vector, vector i at [2i+1:2i]
interface exp3_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        dut_a;
  logic        dut_b;
  logic        dut_c;
  logic        dut_x;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  err_count;
  logic [7:0]  fail_mask;
  logic [15:0] results;

  // Front end plus the exp_3 block: drives requests and DUT outputs.
  modport master (
    output start, abort, dut_x, dut_y,
    input  dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_mask, results
  );

  // The sweep sequencer.
  modport slave (
    input  start, abort, dut_x, dut_y,
    output dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_mask, results
  );
endinterface

// File: rtl/exp3_sweep_ctrl.sv
// Self-test sequencer: drives all 8 vectors to exp_3, samples x/y, compares with a golden model.
// Latency: done pulses 8*(SETTLE_CYCLES+1)+1 cycles after the accepted start edge.
// Backpressure: none; start is ignored unless idle, abort cancels a sweep in progress.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of exp3_sweep_ctrl_if (requests, DUT vector/response, status)
module exp3_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2  // legal 1..15
) (
  input  logic            clk,
  input  logic            rst_n,
  exp3_sweep_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  idx;      // doubles as the driven vector {a,b,c}
  logic        done_q;
  logic        pass_q;
  logic [3:0]  err_q;
  logic [7:0]  fail_q;
  logic [15:0] res_q;

  logic        x_exp;
  logic        y_exp;
  logic        mismatch;
  logic [3:0]  err_nxt;

  // Golden model for the vector currently applied.
  always_comb begin
    x_exp    = ~idx[0] ^ (idx[2] | idx[1]);
    y_exp    = idx[2] & idx[1];
    mismatch = (bus.dut_x != x_exp) || (bus.dut_y != y_exp);
    err_nxt  = err_q + (mismatch ? 4'd1 : 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      idx    <= 3'd0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 4'd0;
      fail_q <= 8'd0;
      res_q  <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            res_q  <= 16'd0;
            fail_q <= 8'd0;
            err_q  <= 4'd0;
            pass_q <= 1'b0;
            idx    <= 3'd0;
            cnt    <= 4'd0;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            idx    <= 3'd0;
            cnt    <= 4'd0;
            pass_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == SETTLE_LAST) state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // An abort here wins over the capture so the partial results stay consistent.
          if (bus.abort) begin
            idx    <= 3'd0;
            cnt    <= 4'd0;
            pass_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            res_q[{idx, 1'b0} +: 2] <= {bus.dut_y, bus.dut_x};
            if (mismatch) begin
              fail_q[idx] <= 1'b1;
              err_q       <= err_nxt;
            end
            if (idx == 3'd7) begin
              // err_nxt already folds in vector 7, so pass is valid from DONE onward.
              done_q <= 1'b1;
              pass_q <= (err_nxt == 4'd0);
              state  <= ST_DONE;
            end else begin
              idx   <= idx + 3'd1;
              cnt   <= 4'd0;
              state <= ST_SETTLE;
            end
          end
        end
        default: begin  // ST_DONE
          idx   <= 3'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_a     = idx[2];
  assign bus.dut_b     = idx[1];
  assign bus.dut_c     = idx[0];
  assign bus.busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = fail_q;
  assign bus.results   = res_q;

endmodule

// File: tb/tb_exp3_sweep_ctrl.sv
module tb_exp3_sweep_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   mode0;  // 0 correct exp_3, 1 y stuck at 0, 2 x inverted
  int   mode1;

  exp3_sweep_ctrl_if if0 ();
  exp3_sweep_ctrl_if if1 ();

  exp3_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  exp3_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Behavioural exp_3 blocks with optional faults.
  assign if0.dut_x = (mode0 == 2) ? (if0.dut_c ^ (if0.dut_a | if0.dut_b))
                                  : (~if0.dut_c ^ (if0.dut_a | if0.dut_b));
  assign if0.dut_y = (mode0 == 1) ? 1'b0 : (if0.dut_a & if0.dut_b);
  assign if1.dut_x = (mode1 == 2) ? (if1.dut_c ^ (if1.dut_a | if1.dut_b))
                                  : (~if1.dut_c ^ (if1.dut_a | if1.dut_b));
  assign if1.dut_y = (mode1 == 1) ? 1'b0 : (if1.dut_a & if1.dut_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start on instance 0; returns at the falling edge of cycle 1 after the start edge.
  task automatic start0();
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  // Observe instance 0 for a fixed window starting at cycle 1.
  task automatic run0(input int ncyc, output int done_cyc, output int busy_n,
                      output int done_n, output logic [2:0] abc_at10);
    done_cyc = 0; busy_n = 0; done_n = 0; abc_at10 = 3'b000;
    for (int k = 1; k <= ncyc; k++) begin
      if (if0.busy) busy_n++;
      if (if0.done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (k == 10) abc_at10 = {if0.dut_a, if0.dut_b, if0.dut_c};
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b, if0.dut_c} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b, if0.dut_c});
    end
    checks++;
    if ({if0.err_count, if0.fail_mask, if0.results} !== 28'h0) begin
      errors++; $display("FAIL reset_status: got %h expected 0",
        {if0.err_count, if0.fail_mask, if0.results});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_sweep(input string name, input int mode, input logic [15:0] exp_res,
                             input logic [7:0] exp_fail, input logic [3:0] exp_err,
                             input logic exp_pass);
    int dc, bn, dn;
    logic [2:0] abc;
    mode0 = mode;
    start0();
    run0(40, dc, bn, dn, abc);
    checks++;
    if (dc !== 25 || dn !== 1 || bn !== 24) begin
      errors++; $display("FAIL %s_timing: done_cycle=%0d done_pulses=%0d busy=%0d expected 25/1/24",
        name, dc, dn, bn);
    end
    checks++;
    if (abc !== 3'b011) begin
      errors++; $display("FAIL %s_vector_at_cycle10: got %b expected 011", name, abc);
    end
    checks++;
    if (if0.results !== exp_res) begin
      errors++; $display("FAIL %s_results: got %h expected %h", name, if0.results, exp_res);
    end
    checks++;
    if (if0.fail_mask !== exp_fail || if0.err_count !== exp_err) begin
      errors++; $display("FAIL %s_mask_err: got %h/%0d expected %h/%0d",
        name, if0.fail_mask, if0.err_count, exp_fail, exp_err);
    end
    checks++;
    if (if0.pass !== exp_pass || {if0.dut_a, if0.dut_b, if0.dut_c} !== 3'b000) begin
      errors++; $display("FAIL %s_pass_idle: pass=%b abc=%b expected %b/000", name, if0.pass,
        {if0.dut_a, if0.dut_b, if0.dut_c}, exp_pass);
    end
  endtask

  task automatic test_clean();
    check_sweep("clean", 0, 16'hE441, 8'h00, 4'd0, 1'b1);
  endtask

  // Slot 6 {y,x}=10 becomes 00 and slot 7 11 becomes 01.
  task automatic test_y_stuck();
    check_sweep("y_stuck", 1, 16'h4441, 8'hC0, 4'd2, 1'b0);
  endtask

  // Every x bit flips: 0xE441 ^ 0x5555.
  task automatic test_x_inverted();
    check_sweep("x_inv", 2, 16'hB114, 8'hFF, 4'd8, 1'b0);
  endtask

  task automatic test_abort();
    int dc, bn, dn;
    logic [2:0] abc;
    mode0 = 0;
    start0();
    for (int k = 1; k < 10; k++) @(negedge clk);  // cycle 10: vector 3 SETTLE
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    checks++;
    if (if0.busy !== 1'b0 || {if0.dut_a, if0.dut_b, if0.dut_c} !== 3'b000 || if0.pass !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy=%b abc=%b pass=%b expected 0/000/0",
        if0.busy, {if0.dut_a, if0.dut_b, if0.dut_c}, if0.pass);
    end
    checks++;
    if (if0.results !== 16'h0001 || if0.fail_mask[7:3] !== 5'b0 || if0.err_count !== 4'd0) begin
      errors++; $display("FAIL abort_partial: results=%h mask=%h err=%0d expected 0001/00/0",
        if0.results, if0.fail_mask, if0.err_count);
    end
    run0(30, dc, bn, dn, abc);
    checks++;
    if (dn !== 0 || bn !== 0) begin
      errors++; $display("FAIL abort_quiet: done_pulses=%0d busy=%0d expected 0/0", dn, bn);
    end
    check_sweep("after_abort", 0, 16'hE441, 8'h00, 4'd0, 1'b1);
  endtask

  task automatic test_start_ignored();
    int dc, dn, bn;
    mode0 = 0;
    start0();
    dc = 0; dn = 0;
    for (int k = 1; k <= 60; k++) begin
      if0.start = (k == 5 || k == 25);  // mid-sweep and during DONE
      if (if0.done) begin
        dn++;
        if (dc == 0) dc = k;
      end
      @(negedge clk);
    end
    if0.start = 1'b0;
    checks++;
    if (dc !== 25 || dn !== 1) begin
      errors++; $display("FAIL start_ignored: done_cycle=%0d pulses=%0d expected 25/1", dc, dn);
    end
    if0.start = 1'b1;
    if0.abort = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if0.abort = 1'b0;
    bn = 0;
    for (int k = 0; k < 30; k++) begin
      if (if0.busy || if0.done) bn++;
      @(negedge clk);
    end
    checks++;
    if (bn !== 0 || if0.results !== 16'hE441 || if0.pass !== 1'b1) begin
      errors++; $display("FAIL start_abort_together: active=%0d results=%h pass=%b expected 0/e441/1",
        bn, if0.results, if0.pass);
    end
  endtask

  task automatic test_async_reset();
    int dn;
    mode0 = 0;
    start0();
    dn = 0;
    for (int k = 1; k < 16; k++) begin  // cycle 16: vector 5 SETTLE
      if (if0.done) dn++;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b, if0.dut_c} !== 6'b0 ||
        {if0.err_count, if0.fail_mask, if0.results} !== 28'h0) begin
      errors++; $display("FAIL async_reset: ctrl=%b status=%h expected 0/0",
        {if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b, if0.dut_c},
        {if0.err_count, if0.fail_mask, if0.results});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (if0.done || if0.busy) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL async_reset_quiet: activity=%0d expected 0", dn);
    end
  endtask

  task automatic test_settle1();
    int dc, dn, bn;
    mode1 = 0;
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    dc = 0; dn = 0; bn = 0;
    for (int k = 1; k <= 30; k++) begin
      if (if1.busy) bn++;
      if (if1.done) begin
        dn++;
        if (dc == 0) dc = k;
      end
      @(negedge clk);
    end
    checks++;
    if (dc !== 17 || dn !== 1 || bn !== 16) begin
      errors++; $display("FAIL settle1_timing: done_cycle=%0d pulses=%0d busy=%0d expected 17/1/16",
        dc, dn, bn);
    end
    checks++;
    if (if1.results !== 16'hE441 || if1.pass !== 1'b1 || if1.err_count !== 4'd0) begin
      errors++; $display("FAIL settle1_result: results=%h pass=%b err=%0d expected e441/1/0",
        if1.results, if1.pass, if1.err_count);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mode0 = 0;
    mode1 = 0;
    rst_n = 1'b0;
    if0.start = 1'b0;
    if0.abort = 1'b0;
    if1.start = 1'b0;
    if1.abort = 1'b0;
    test_reset();
    test_clean();
    test_y_stuck();
    test_x_inverted();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_settle1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
